// File: rtl/riscv_trace_pkg.sv
// riscv_trace_pkg: shared state encoding and tap channel indices for the trace buffer
package riscv_trace_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, POST = 2'd2, DONE = 2'd3} trace_state_e;
  localparam int CH_PC    = 0;
  localparam int CH_INSTR = 1;
  localparam int CH_RD1   = 2;
  localparam int CH_RD2   = 3;
  localparam int CH_ALU   = 4;
endpackage

// File: rtl/trace_ram.sv
// trace_ram: flop array with one synchronous write port and one asynchronous read port
module trace_ram #(
  parameter int DEPTH = 16,
  parameter int W = 176
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);
  logic [W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk)
    if (we) mem_q[waddr] <= wdata;
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/riscv_trace_buffer.sv
// riscv_trace_buffer: circular trace capture of core taps with PC trigger and oldest-first readout
module riscv_trace_buffer
  import riscv_trace_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NCH = 5,
  parameter int DEPTH = 16,
  parameter int TS_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       arm,
  input  logic                       stop,
  input  logic                       cap_en,
  input  logic [NCH*XLEN-1:0]        taps,
  input  logic                       trig_en,
  input  logic [XLEN-1:0]            trig_pc,
  input  logic [$clog2(DEPTH):0]     post_cnt,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [TS_W+NCH*XLEN-1:0]   rd_data,
  output logic                       rd_last,
  output logic [1:0]                 state_o,
  output logic [$clog2(DEPTH):0]     fill_o,
  output logic                       triggered_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int W = TS_W + NCH * XLEN;
  trace_state_e state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, raddr;
  logic [CW-1:0] fill_q, fill_d, rd_cnt_q, rd_cnt_d, rem_q, rem_d, post_clamp;
  logic [TS_W-1:0] ts_q, ts_d;
  logic trig_q, trig_d, we, hit, full, capturing;
  logic [W-1:0] rdata;
  assign capturing = state_q == ARMED || state_q == POST;
  assign hit = trig_en && taps[CH_PC*XLEN +: XLEN] == trig_pc;
  assign full = fill_q == CW'(DEPTH);
  assign post_clamp = post_cnt > CW'(DEPTH - 1) ? CW'(DEPTH - 1) : post_cnt;
  assign raddr = wr_ptr_q - fill_q[AW-1:0] + rd_cnt_q[AW-1:0];
  assign rd_valid = state_q == DONE && rd_cnt_q < fill_q;
  assign rd_last = rd_valid && rd_cnt_q == fill_q - CW'(1);
  assign rd_data = rd_valid ? rdata : '0;
  assign state_o = state_q;
  assign fill_o = fill_q;
  assign triggered_o = trig_q;
  always_comb begin
    state_d = state_q;
    wr_ptr_d = wr_ptr_q;
    fill_d = fill_q;
    ts_d = ts_q;
    rd_cnt_d = rd_cnt_q;
    rem_d = rem_q;
    trig_d = trig_q;
    we = 1'b0;
    if ((state_q == IDLE || state_q == DONE) && arm) begin
      state_d = ARMED;
      wr_ptr_d = '0;
      fill_d = '0;
      ts_d = '0;
      rd_cnt_d = '0;
      trig_d = 1'b0;
    end else if (capturing) begin
      ts_d = ts_q + TS_W'(1);
      if (stop) state_d = DONE;
      else if (cap_en) begin
        we = 1'b1;
        wr_ptr_d = wr_ptr_q + AW'(1);
        fill_d = full ? fill_q : fill_q + CW'(1);
        if (state_q == ARMED && hit) begin
          trig_d = 1'b1;
          rem_d = post_clamp;
          state_d = post_clamp == '0 ? DONE : POST;
        end else if (state_q == POST) begin
          rem_d = rem_q - CW'(1);
          state_d = rem_q == CW'(1) ? DONE : POST;
        end
      end
    end else if (state_q == DONE) begin
      if (fill_q == '0) state_d = IDLE;
      else if (rd_valid && rd_ready) begin
        rd_cnt_d = rd_cnt_q + CW'(1);
        state_d = rd_last ? IDLE : DONE;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wr_ptr_q <= '0;
      fill_q <= '0;
      ts_q <= '0;
      rd_cnt_q <= '0;
      rem_q <= '0;
      trig_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      fill_q <= fill_d;
      ts_q <= ts_d;
      rd_cnt_q <= rd_cnt_d;
      rem_q <= rem_d;
      trig_q <= trig_d;
    end
  end
  trace_ram #(.DEPTH(DEPTH), .W(W)) u_ram (
    .clk(clk),
    .we(we),
    .waddr(wr_ptr_q),
    .wdata({ts_q, taps}),
    .raddr(raddr),
    .rdata(rdata)
  );
endmodule

// File: tb/tb_riscv_trace_buffer.sv
// tb_riscv_trace_buffer: directed scenario checks of capture, trigger, wrap, readout and reset
module tb_riscv_trace_buffer;
  logic clk = 1'b0, rst = 1'b0, arm = 1'b0, stop = 1'b0, cap_en = 1'b0, trig_en = 1'b0, rd_ready = 1'b0;
  logic [159:0] taps = '0;
  logic [31:0] trig_pc = '0;
  logic [4:0] post_cnt = '0;
  logic rd_valid, rd_last, triggered_o;
  logic [175:0] rd_data;
  logic [1:0] state_o;
  logic [4:0] fill_o;
  int checks = 0, passed = 0;
  riscv_trace_buffer dut (
    .clk(clk), .rst(rst), .arm(arm), .stop(stop), .cap_en(cap_en), .taps(taps),
    .trig_en(trig_en), .trig_pc(trig_pc), .post_cnt(post_cnt), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last), .state_o(state_o),
    .fill_o(fill_o), .triggered_o(triggered_o)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic cap(input logic [31:0] pc);
    cap_en = 1'b1;
    taps = {96'd0, pc ^ 32'hA5A5_0000, pc};
    tick();
    cap_en = 1'b0;
  endtask
  task automatic do_arm;
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask
  task automatic do_stop;
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({state_o, fill_o, rd_valid, rd_last, triggered_o} !== 10'd0 || rd_data !== '0)
      $display("FAIL reset: state=%0d fill=%0d valid=%b last=%b trig=%b data=%h, want all 0", state_o, fill_o, rd_valid, rd_last, triggered_o, rd_data);
    else passed++;
  endtask
  task automatic test_basic;
    do_arm();
    for (int i = 0; i < 5; i++) cap(32'(4 * i));
    cap_en = 1'b1;
    taps = {128'd0, 32'h99};
    do_stop();
    cap_en = 1'b0;
    checks++;
    if (state_o !== 2'd3 || fill_o !== 5'd5) $display("FAIL basic_done: state=%0d fill=%0d, want 3/5", state_o, fill_o);
    else passed++;
    rd_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (!rd_valid || rd_data[31:0] !== 32'(4 * i) || rd_data[175:160] !== 16'(i) || rd_last !== (i == 4) || rd_data[63:32] !== (32'(4 * i) ^ 32'hA5A5_0000))
        $display("FAIL basic_read%0d: valid=%b pc=%h ts=%0d last=%b, want 1/%h/%0d/%b", i, rd_valid, rd_data[31:0], rd_data[175:160], rd_last, 4 * i, i, i == 4);
      else passed++;
      tick();
    end
    rd_ready = 1'b0;
    checks++;
    if (state_o !== 2'd0 || rd_valid !== 1'b0) $display("FAIL basic_idle: state=%0d valid=%b, want 0/0", state_o, rd_valid);
    else passed++;
  endtask
  task automatic test_trigger;
    logic [31:0] last_pc = 32'hFFFF_FFFF;
    trig_en = 1'b1;
    trig_pc = 32'h20;
    post_cnt = 5'd3;
    do_arm();
    for (int i = 0; i < 40; i++) begin
      cap(32'(4 * i));
      if (state_o == 2'd3) begin
        last_pc = 32'(4 * i);
        break;
      end
    end
    checks++;
    if (last_pc !== 32'h2C || fill_o !== 5'd12 || triggered_o !== 1'b1)
      $display("FAIL trig_done: last_pc=%h fill=%0d trig=%b, want 2c/12/1", last_pc, fill_o, triggered_o);
    else passed++;
    rd_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (!rd_valid || rd_data[31:0] !== 32'(4 * i) || rd_last !== (i == 11))
        $display("FAIL trig_read%0d: valid=%b pc=%h last=%b, want 1/%h/%b", i, rd_valid, rd_data[31:0], rd_last, 4 * i, i == 11);
      else passed++;
      tick();
    end
    rd_ready = 1'b0;
    trig_en = 1'b0;
  endtask
  task automatic test_wrap;
    do_arm();
    for (int i = 0; i < 40; i++) cap(32'(4 * i));
    do_stop();
    checks++;
    if (fill_o !== 5'd16) $display("FAIL wrap_fill: fill=%0d, want 16", fill_o);
    else passed++;
    rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (!rd_valid || rd_data[31:0] !== 32'(4 * (24 + i)) || rd_data[175:160] !== 16'(24 + i))
        $display("FAIL wrap_read%0d: valid=%b pc=%h ts=%0d, want 1/%h/%0d", i, rd_valid, rd_data[31:0], rd_data[175:160], 4 * (24 + i), 24 + i);
      else passed++;
      tick();
    end
    rd_ready = 1'b0;
    checks++;
    if (state_o !== 2'd0) $display("FAIL wrap_idle: state=%0d, want 0", state_o);
    else passed++;
  endtask
  task automatic test_post_zero;
    trig_en = 1'b1;
    trig_pc = 32'h8;
    post_cnt = 5'd0;
    do_arm();
    cap(32'h0);
    cap(32'h4);
    checks++;
    if (state_o !== 2'd1) $display("FAIL post0_armed: state=%0d, want 1", state_o);
    else passed++;
    cap(32'h8);
    checks++;
    if (state_o !== 2'd3 || fill_o !== 5'd3) $display("FAIL post0_done: state=%0d fill=%0d, want 3/3", state_o, fill_o);
    else passed++;
    rd_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (!rd_last || rd_data[31:0] !== 32'h8) $display("FAIL post0_last: last=%b pc=%h, want 1/8", rd_last, rd_data[31:0]);
    else passed++;
    tick();
    rd_ready = 1'b0;
    trig_en = 1'b0;
  endtask
  task automatic test_clamp;
    int n = 0;
    trig_en = 1'b1;
    trig_pc = 32'h0;
    post_cnt = 5'd31;
    do_arm();
    for (int i = 0; i < 40; i++) begin
      cap(32'(4 * i));
      n++;
      if (state_o == 2'd3) break;
    end
    checks++;
    if (n !== 16 || fill_o !== 5'd16 || rd_data[31:0] !== 32'h0 || !rd_valid)
      $display("FAIL clamp: caps=%0d fill=%0d first_pc=%h valid=%b, want 16/16/0/1", n, fill_o, rd_data[31:0], rd_valid);
    else passed++;
    rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    rd_ready = 1'b0;
    checks++;
    if (state_o !== 2'd0) $display("FAIL clamp_idle: state=%0d, want 0", state_o);
    else passed++;
    trig_en = 1'b0;
  endtask
  task automatic test_back_to_back;
    int idx = 0;
    logic [175:0] prev = '0;
    logic stalled = 1'b0;
    logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    do_arm();
    cap(32'h100);
    cap(32'h104);
    cap(32'h108);
    do_stop();
    for (int c = 0; c < 20 && state_o == 2'd3; c++) begin
      checks++;
      if (!rd_valid || rd_data[31:0] !== 32'h100 + 32'(4 * idx) || (stalled && rd_data !== prev))
        $display("FAIL bp_cycle%0d: valid=%b pc=%h held=%b, want 1/%h/1", c, rd_valid, rd_data[31:0], !stalled || rd_data === prev, 32'h100 + 4 * idx);
      else passed++;
      rd_ready = pat[c % 4];
      prev = rd_data;
      stalled = !rd_ready;
      tick();
      if (rd_ready) idx++;
    end
    rd_ready = 1'b0;
    checks++;
    if (idx !== 3 || state_o !== 2'd0) $display("FAIL bp_count: transfers=%0d state=%0d, want 3/0", idx, state_o);
    else passed++;
  endtask
  task automatic test_rst_post;
    trig_en = 1'b1;
    trig_pc = 32'h0;
    post_cnt = 5'd5;
    do_arm();
    cap(32'h0);
    checks++;
    if (state_o !== 2'd2 || triggered_o !== 1'b1) $display("FAIL rst_post_state: state=%0d trig=%b, want 2/1", state_o, triggered_o);
    else passed++;
    cap(32'h4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (state_o !== 2'd0 || fill_o !== 5'd0 || rd_valid !== 1'b0) $display("FAIL rst_post: state=%0d fill=%0d valid=%b, want 0/0/0", state_o, fill_o, rd_valid);
    else passed++;
    trig_en = 1'b0;
    do_arm();
    cap(32'h40);
    do_stop();
    checks++;
    if (fill_o !== 5'd1 || rd_data[31:0] !== 32'h40 || rd_data[175:160] !== 16'd0 || triggered_o !== 1'b0)
      $display("FAIL rst_rearm: fill=%0d pc=%h ts=%0d trig=%b, want 1/40/0/0", fill_o, rd_data[31:0], rd_data[175:160], triggered_o);
    else passed++;
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
  endtask
  initial begin
    tick();
    test_reset();
    test_basic();
    test_trigger();
    test_wrap();
    test_post_zero();
    test_clamp();
    test_back_to_back();
    test_rst_post();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/riscv_trace_buffer.md
# riscv_trace_buffer

Synthesizable trace capture unit for the single-cycle `riscv` core. It records the core's debug taps (pc, instr, rd1, rd2, alu_res) into a circular buffer and stops capturing a programmable number of cycles after a PC-match trigger. A host or bench then drains the captured entries oldest-first over a valid/ready port. It sits beside the core and replaces ad-hoc `$monitor` observation in simulation and on FPGA.

## Interface
- `XLEN`, 32: width of each tap channel.
- `NCH`, 5: number of tap channels. Channel 0 is always pc.
- `DEPTH`, 16: buffer entries. Must be a power of two, ≥2.
- `TS_W`, 16: timestamp width.
- `clk` in 1: the only clock. All logic is on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `arm` in 1: pulse; starts a new capture.
- `stop` in 1: forces capture to end.
- `cap_en` in 1: core advanced this cycle; sample the taps.
- `taps` in NCH*XLEN: channel k occupies bits [k*XLEN +: XLEN].
- `trig_en` in 1: enables the PC-match trigger.
- `trig_pc` in XLEN: trigger address.
- `post_cnt` in $clog2(DEPTH)+1: number of entries to capture after the trigger entry. Sampled when the trigger fires.
- `rd_valid` out 1: readout entry available.
- `rd_ready` in 1: consumer accepts the entry.
- `rd_data` out TS_W+NCH*XLEN: entry layout is {timestamp, taps}.
- `rd_last` out 1: the current entry is the final one.
- `state_o` out 2: current FSM state.
- `fill_o` out $clog2(DEPTH)+1: number of valid entries.
- `triggered_o` out 1: the trigger fired in the current or last capture.

## Operation
- States: IDLE=0, ARMED=1, POST=2, DONE=3.
- On reset: state IDLE; wr_ptr, rd_cnt, fill, ts, remaining and triggered are all 0. `rd_valid`=0, `rd_last`=0, `rd_data`=0.
- IDLE:
  - `arm` → ARMED; clear wr_ptr, fill, ts and triggered.
- ARMED:
  - ts increments every cycle and wraps at 2^TS_W.
  - When `cap_en`=1: write {ts, taps} at wr_ptr; wr_ptr+1 mod DEPTH; fill saturates at DEPTH. Once full, the oldest entry is overwritten.
  - Trigger condition: `cap_en` && `trig_en` && taps[XLEN-1:0]==`trig_pc`.
  - On trigger: the trigger entry is written; triggered=1; remaining=`post_cnt`. Next state is DONE if `post_cnt`==0, otherwise POST.
- POST:
  - Each `cap_en` writes an entry and decrements remaining.
  - The write that takes remaining from 1 to 0 moves the FSM to DONE.
  - `post_cnt` values above DEPTH-1 are clamped to DEPTH-1, so the trigger entry is never overwritten.
- `stop` in ARMED or POST → DONE.
  - No write occurs in the cycle `stop` is asserted.
  - Priority: `rst` > `stop` > trigger > write.
- `arm` in ARMED or POST is ignored. `arm` in DONE discards the buffer and re-enters ARMED.
- DONE:
  - The oldest entry is at index (wr_ptr − fill) mod DEPTH.
  - `rd_valid`=1 while rd_cnt < fill. `rd_data` is the entry at oldest+rd_cnt.
  - `rd_last`=`rd_valid` && (rd_cnt==fill−1).
  - A transfer occurs on `rd_valid`&&`rd_ready` and increments rd_cnt.
  - The transfer with `rd_last` high → IDLE.
  - If fill==0 on entering DONE, `rd_valid` stays 0 and the FSM moves to IDLE on the next cycle.
- `triggered_o` holds its value until the next `arm`.

## Timing
- Capture: taps are sampled on the `cap_en` edge. `fill_o` reflects the write one cycle later.
- Transition into DONE is registered. `rd_valid` can first be 1 in the cycle after `state_o`==DONE is visible… more precisely, `rd_valid` is combinational from state and rd_cnt, so it is 1 in the first DONE cycle.
- Readout is an asynchronous read of the register array. Throughput is one entry per cycle when `rd_ready` is held high.
- `rd_data` must stay stable while `rd_valid`=1 and `rd_ready`=0.
- `rst` mid-capture or mid-readout returns to IDLE on that edge. Entries are not cleared, but fill=0 makes them invisible.

## Structure
- Package `riscv_trace_pkg` holds:
  - the `trace_state_e` enum (IDLE, ARMED, POST, DONE);
  - channel index constants CH_PC=0, CH_INSTR=1, CH_RD1=2, CH_RD2=3, CH_ALU=4.
- Sub-module `trace_ram`: DEPTH×W flop array with one synchronous write port and one asynchronous read port, where W = TS_W+NCH*XLEN.
- The FSM, pointers and counters live in the top module.

## Test plan
- Arm, 5 captures of pc 0,4,…,16, then `stop` → fill_o=5. Readout gives pc 0..16 in order with ts increasing; `rd_last` is high on the 5th entry; FSM then returns to IDLE.
- Arm with `trig_pc`=0x20, `post_cnt`=3, pc stepping by 4 from 0 → DONE after the pc=0x2C capture; fill=12; `triggered_o`=1; last three entries are 0x24, 0x28, 0x2C.
- Wrap-around: 40 captures with `stop`, DEPTH=16 → fill=16; readout pcs are those of captures 24..39 in order.
- Trigger with `post_cnt`=0 → DONE in the next cycle; the last read entry is the trigger pc.
- Backpressure: toggle `rd_ready` 1,0,0,1 → `rd_data` holds across stalls; each entry is transferred exactly once.
- `rst` asserted during POST → next cycle `state_o`=0, `fill_o`=0, `rd_valid`=0; a following `arm` starts a clean capture with ts=0.
